ex_hazard_ctrl: RTL and testbench

- Issue and hazard controller for the execute stage; it sequences the ALU.
- Accepts decoded instructions from decode over a valid/ready handshake and drives the ALU-side valid.
- Tracks the destinations of in-flight EX/MEM/WB instructions, generates per-operand forwarding selects, and inserts a load-use bubble.
- Drains wrong-path instructions after an EX-resolved branch/jump redirect.

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/hazard_fwd_unit.sv | 47 ++++
 rtl/ex_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: opcodes, forwarding selects, EX controller
// state and the per-stage destination tag used for hazard tracking.
package riscv_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    // Tags carry rd zero-extended to a fixed width so the struct is
    // independent of the REG_AW chosen by each instance.
    localparam int TAG_AW = 8;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ex_ctrl_state_e;

    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] rd;
        logic              is_load;
    } stage_tag_t;

    // x0 is hardwired, so a tag writing it never produces a hazard.
    function automatic logic tag_hit(input stage_tag_t t, input logic [TAG_AW-1:0] rs);
        return t.valid && (t.rd != '0) && (t.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use detection and per-operand forwarding selection for
// the instruction currently offered by decode.
module hazard_fwd_unit
    import riscv_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  stage_tag_t        ex_tag,
    input  stage_tag_t        mem_tag,
    output logic              load_use,
    output fwd_sel_e          fwd_a,
    output fwd_sel_e          fwd_b
);

    logic [TAG_AW-1:0] rs1;
    logic [TAG_AW-1:0] rs2;

    assign rs1 = TAG_AW'(id_rs1);
    assign rs2 = TAG_AW'(id_rs2);

    // EX is checked first so the youngest producer wins; a load in EX has no
    // result yet and is handled by the load-use bubble instead.
    function automatic fwd_sel_e pick(input logic used, input logic [TAG_AW-1:0] rs,
                                      input stage_tag_t ex, input stage_tag_t mem);
        if (!used)
            return FWD_RF;
        else if (tag_hit(ex, rs) && !ex.is_load)
            return FWD_EXMEM;
        else if (tag_hit(mem, rs))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    assign load_use = id_valid && ex_tag.valid && ex_tag.is_load &&
                      ((id_uses_rs1 && tag_hit(ex_tag, rs1)) ||
                       (id_uses_rs2 && tag_hit(ex_tag, rs2)));

    assign fwd_a = pick(id_uses_rs1, rs1, ex_tag, mem_tag);
    assign fwd_b = pick(id_uses_rs2, rs2, ex_tag, mem_tag);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage issue controller: accepts decoded instructions, tracks
// in-flight destinations, inserts load-use bubbles and drains after redirects.
module ex_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [6:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_ready,
    input  logic              ex_redirect,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic [1:0]        ex_fwd_a_sel,
    output logic [1:0]        ex_fwd_b_sel,
    output logic              flush_id,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    ex_ctrl_state_e state, state_nxt;
    logic [3:0]     flush_left, flush_left_nxt;
    stage_tag_t     ex_tag, mem_tag, wb_tag;
    stage_tag_t     id_tag;
    fwd_sel_e       fwd_a, fwd_b, fwd_a_q, fwd_b_q;
    logic           load_use;
    logic           issue, discard, stall;

    hazard_fwd_unit #(
        .REG_AW(REG_AW)
    ) u_hfu (
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2),
        .ex_tag     (ex_tag),
        .mem_tag    (mem_tag),
        .load_use   (load_use),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
    );

    assign id_tag = '{valid: 1'b1, rd: TAG_AW'(id_rd), is_load: (id_opcode == OPCODE_LOAD)};

    always_comb begin
        state_nxt      = state;
        flush_left_nxt = flush_left;
        id_ready       = 1'b0;
        flush_id       = 1'b0;
        issue          = 1'b0;
        discard        = 1'b0;
        stall          = 1'b0;
        case (state)
            RUN: begin
                // A taken redirect overrides any load-use on the wrong-path instruction.
                if (ex_redirect && ex_tag.valid && ex_ready) begin
                    id_ready       = 1'b1;
                    flush_id       = id_valid;
                    discard        = id_valid;
                    state_nxt      = FLUSH;
                    flush_left_nxt = FLUSH_INIT;
                end else begin
                    id_ready = ex_ready && !load_use;
                    issue    = id_valid && id_ready;
                    stall    = ex_ready && load_use;
                end
            end
            FLUSH: begin
                id_ready = ex_ready;
                flush_id = id_valid;
                discard  = id_valid && ex_ready;
                if (ex_ready) begin
                    flush_left_nxt = flush_left - 4'd1;
                    if (flush_left <= 4'd1)
                        state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_left <= '0;
            ex_tag     <= '0;
            mem_tag    <= '0;
            wb_tag     <= '0;
            fwd_a_q    <= FWD_RF;
            fwd_b_q    <= FWD_RF;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            flush_left <= flush_left_nxt;
            if (ex_ready) begin
                ex_tag  <= issue ? id_tag : '0;
                fwd_a_q <= issue ? fwd_a : FWD_RF;
                fwd_b_q <= issue ? fwd_b : FWD_RF;
                mem_tag <= ex_tag;
                wb_tag  <= mem_tag;
            end
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (discard && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign ex_valid     = ex_tag.valid;
    assign ex_rd        = ex_tag.rd[REG_AW-1:0];
    assign ex_fwd_a_sel = fwd_a_q;
    assign ex_fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Vector-table bench for ex_hazard_ctrl; per-cycle expectations are queued
// when inputs are driven and compared once the clock edge has taken them.
module tb_ex_hazard_ctrl;
    import riscv_pkg::*;

    localparam int AW = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_ready;
    logic [6:0]    id_opcode;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_uses_rs1, id_uses_rs2;
    logic          ex_ready, ex_redirect;
    logic          ex_valid;
    logic [AW-1:0] ex_rd;
    logic [1:0]    ex_fwd_a_sel, ex_fwd_b_sel;
    logic          flush_id;
    logic [CW-1:0] stall_cnt, flush_cnt;

    ex_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_ready(ex_ready), .ex_redirect(ex_redirect),
        .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel),
        .flush_id(flush_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rst, iv, op, rs1, rs2, rd, u1, u2, rdy, redir;
        int e_rdy, e_fl, e_exv, e_rd, e_fa, e_fb, e_sc, e_fc;
    } vec_t;

    typedef struct {
        int idx, exv, rd, fa, fb, sc, fc;
    } exp_t;

    localparam int ADD = 7'h33;
    localparam int LW  = 7'h03;
    localparam int NOP = 7'h13;
    localparam int BR  = 7'h63;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t v(int rst_i, int iv, int op, int rs1, int rs2, int rd, int u1, int u2,
                               int rdy, int redir, int e_rdy, int e_fl, int e_exv, int e_rd,
                               int e_fa, int e_fb, int e_sc, int e_fc);
        vec_t r;
        r = '{rst_i, iv, op, rs1, rs2, rd, u1, u2, rdy, redir,
              e_rdy, e_fl, e_exv, e_rd, e_fa, e_fb, e_sc, e_fc};
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    initial begin
        // fields: rst iv op rs1 rs2 rd u1 u2 rdy redir | id_ready flush_id ; ex_valid ex_rd a b stall flush
        tbl.push_back(v(1,0,ADD,0,0,0,0,0,1,0,   1,0, 0,0,0,0,0,0));
        // EX/MEM, MEM/WB and regfile distance for a dependent ADD
        tbl.push_back(v(0,1,ADD,1,2,5,1,1,1,0,   1,0, 1,5,0,0,0,0));
        tbl.push_back(v(0,1,ADD,5,1,6,1,1,1,0,   1,0, 1,6,1,0,0,0));
        tbl.push_back(v(0,0,ADD,0,0,0,0,0,1,0,   1,0, 0,0,0,0,0,0));
        tbl.push_back(v(0,1,ADD,3,4,9,1,1,1,0,   1,0, 1,9,0,0,0,0));
        tbl.push_back(v(0,1,NOP,0,0,0,1,0,1,0,   1,0, 1,0,0,0,0,0));
        tbl.push_back(v(0,1,ADD,3,9,10,1,1,1,0,  1,0, 1,10,0,2,0,0));
        tbl.push_back(v(0,1,ADD,1,2,11,1,1,1,0,  1,0, 1,11,0,0,0,0));
        tbl.push_back(v(0,1,NOP,0,0,0,1,0,1,0,   1,0, 1,0,0,0,0,0));
        tbl.push_back(v(0,1,NOP,0,0,0,1,0,1,0,   1,0, 1,0,0,0,0,0));
        tbl.push_back(v(0,1,ADD,11,11,12,1,1,1,0,1,0, 1,12,0,0,0,0));
        // load-use: one bubble, then both operands from MEM/WB
        tbl.push_back(v(0,1,LW,2,0,7,1,0,1,0,    1,0, 1,7,0,0,0,0));
        tbl.push_back(v(0,1,ADD,7,7,8,1,1,1,0,   0,0, 0,0,0,0,1,0));
        tbl.push_back(v(0,1,ADD,7,7,8,1,1,1,0,   1,0, 1,8,2,2,1,0));
        // x0 never hazards, even behind a load
        tbl.push_back(v(0,1,ADD,1,2,0,1,1,1,0,   1,0, 1,0,0,0,1,0));
        tbl.push_back(v(0,1,ADD,0,0,1,1,1,1,0,   1,0, 1,1,0,0,1,0));
        tbl.push_back(v(0,1,LW,2,0,0,1,0,1,0,    1,0, 1,0,0,0,1,0));
        tbl.push_back(v(0,1,ADD,0,0,2,1,1,1,0,   1,0, 1,2,0,0,1,0));
        // redirect with FLUSH_CYCLES=2: three discards then normal issue
        tbl.push_back(v(0,1,BR,3,4,0,1,1,1,0,    1,0, 1,0,0,0,1,0));
        tbl.push_back(v(0,1,ADD,1,2,13,1,1,1,1,  1,1, 0,0,0,0,1,1));
        tbl.push_back(v(0,1,ADD,1,2,14,1,1,1,0,  1,1, 0,0,0,0,1,2));
        tbl.push_back(v(0,1,ADD,1,2,15,1,1,1,0,  1,1, 0,0,0,0,1,3));
        tbl.push_back(v(0,1,ADD,1,2,16,1,1,1,0,  1,0, 1,16,0,0,1,3));
        // redirect beats load-use, then backpressure inside FLUSH
        tbl.push_back(v(0,1,LW,1,0,20,1,0,1,0,   1,0, 1,20,0,0,1,3));
        tbl.push_back(v(0,1,ADD,20,0,21,1,0,1,1, 1,1, 0,0,0,0,1,4));
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(0,1,ADD,1,2,22,1,1,0,0, 0,1, 0,0,0,0,1,4));
        tbl.push_back(v(0,1,ADD,1,2,22,1,1,1,0,  1,1, 0,0,0,0,1,5));
        tbl.push_back(v(0,1,ADD,1,2,22,1,1,1,0,  1,1, 0,0,0,0,1,6));
        // redirect with an empty EX is ignored
        tbl.push_back(v(0,0,ADD,0,0,0,0,0,1,1,   1,0, 0,0,0,0,1,6));
        // backpressure during a load-use stall
        tbl.push_back(v(0,1,LW,1,0,7,1,0,1,0,    1,0, 1,7,0,0,1,6));
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(0,1,ADD,7,7,8,1,1,0,0, 0,0, 1,7,0,0,1,6));
        tbl.push_back(v(0,1,ADD,7,7,8,1,1,1,0,   0,0, 0,0,0,0,2,6));
        tbl.push_back(v(0,1,ADD,7,7,8,1,1,1,0,   1,0, 1,8,2,2,2,6));
        // redirect held by ex_ready=0, counter saturates at 7
        tbl.push_back(v(0,1,BR,1,2,0,1,1,1,0,    1,0, 1,0,0,0,2,6));
        tbl.push_back(v(0,1,ADD,1,2,9,1,1,0,1,   0,0, 1,0,0,0,2,6));
        tbl.push_back(v(0,1,ADD,1,2,9,1,1,1,1,   1,1, 0,0,0,0,2,7));
        tbl.push_back(v(0,1,ADD,1,2,9,1,1,1,0,   1,1, 0,0,0,0,2,7));
        // reset mid-FLUSH returns to RUN with everything cleared
        tbl.push_back(v(1,1,ADD,1,2,9,1,1,1,0,   1,1, 0,0,0,0,0,0));
        tbl.push_back(v(0,1,ADD,1,2,9,1,1,0,0,   0,0, 0,0,0,0,0,0));
        tbl.push_back(v(0,1,ADD,1,2,9,1,1,1,0,   1,0, 1,9,0,0,0,0));

        rst = 1'b1; id_valid = 1'b0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_ready = 1'b1; ex_redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t t;
            exp_t e;
            t = tbl[i];
            rst         = t.rst[0];
            id_valid    = t.iv[0];
            id_opcode   = t.op[6:0];
            id_rs1      = t.rs1[AW-1:0];
            id_rs2      = t.rs2[AW-1:0];
            id_rd       = t.rd[AW-1:0];
            id_uses_rs1 = t.u1[0];
            id_uses_rs2 = t.u2[0];
            ex_ready    = t.rdy[0];
            ex_redirect = t.redir[0];
            sb.push_back('{i, t.e_exv, t.e_rd, t.e_fa, t.e_fb, t.e_sc, t.e_fc});
            @(negedge clk);
            chk("id_ready", i, int'(id_ready), t.e_rdy);
            chk("flush_id", i, int'(flush_id), t.e_fl);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("ex_valid",  e.idx, int'(ex_valid),     e.exv);
            chk("ex_rd",     e.idx, int'(ex_rd),        e.rd);
            chk("fwd_a",     e.idx, int'(ex_fwd_a_sel), e.fa);
            chk("fwd_b",     e.idx, int'(ex_fwd_b_sel), e.fb);
            chk("stall_cnt", e.idx, int'(stall_cnt),    e.sc);
            chk("flush_cnt", e.idx, int'(flush_cnt),    e.fc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
